// File: rtl/stage_delay_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared state encoding, mode values and default delays for the
//            stage delay sequencer.
// Revision : 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_B    = 2'd1,
        WAIT_C = 2'd2,
        WAIT_D = 2'd3
    } seq_state_t;

    localparam logic MODE_SNAPSHOT = 1'b0;
    localparam logic MODE_LIVE     = 1'b1;

    localparam int DLY1_DEF = 3;
    localparam int DLY2_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/stage_delay_sequencer_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : delay_counter
// Brief    : Loadable down-counter with a zero flag; load wins over enable.
// Revision : 1.0
// ============================================================================
module delay_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stage_delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_delay_sequencer
// Brief    : Three-stage accumulate chain (b=2a, c=b+a, d=c+a) with
//            programmable inter-stage delays and snapshot/live operand.
// Revision : 1.0
// ============================================================================
module stage_delay_sequencer
    import seq_pkg::*;
#(
    parameter int W    = 8,
    parameter int DLY1 = DLY1_DEF,
    parameter int DLY2 = DLY2_DEF,
    parameter int CW   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a_in,
    input  logic         mode,
    output logic [W-1:0] b_out,
    output logic [W-1:0] c_out,
    output logic [W-1:0] d_out,
    output logic         busy,
    output logic         done
);

    if ((DLY1 < 1) || (DLY2 < 1) || (DLY1 >= (1 << CW)) || (DLY2 >= (1 << CW))) begin : g_param_check
        $fatal(1, "stage_delay_sequencer: DLY1/DLY2 must be >= 1 and < 2**CW");
    end

    // The counter is loaded with DLY-1 so that the stage fires DLY edges later.
    localparam logic [CW-1:0] c_dly1_ld = CW'(DLY1 - 1);
    localparam logic [CW-1:0] c_dly2_ld = CW'(DLY2 - 1);

    seq_state_t    r_state;
    seq_state_t    w_state_next;
    logic [W-1:0]  r_a_lat;
    logic          r_mode_lat;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_c;
    logic [W-1:0]  r_d;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  w_opnd;
    logic          w_accept;
    logic          w_ld_b;
    logic          w_ld_c;
    logic          w_ld_d;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_cnt_en;
    logic          w_zero;

    delay_counter #(.CW(CW)) u_delay_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_cnt_en),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_c       = 1'b0;
        w_ld_d       = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_B;
                end
            end
            S_B: begin
                w_ld_b       = 1'b1;
                w_load       = 1'b1;
                w_load_val   = c_dly1_ld;
                w_state_next = WAIT_C;
            end
            WAIT_C: begin
                if (w_zero) begin
                    w_ld_c       = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = c_dly2_ld;
                    w_state_next = WAIT_D;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            WAIT_D: begin
                if (w_zero) begin
                    w_ld_d       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // LIVE mode takes a_in at the firing edge; stage b always uses the latch.
    assign w_opnd = (r_mode_lat == MODE_LIVE) ? a_in : r_a_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_lat    <= '0;
            r_mode_lat <= MODE_SNAPSHOT;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_lat    <= a_in;
                r_mode_lat <= mode;
            end
            if (w_ld_b) r_b <= r_a_lat + r_a_lat;
            if (w_ld_c) r_c <= r_b + w_opnd;
            if (w_ld_d) r_d <= r_c + w_opnd;
            r_busy <= (w_state_next != IDLE);
            r_done <= w_ld_d;
        end
    end

    assign start_ready = (r_state == IDLE);
    assign b_out       = r_b;
    assign c_out       = r_c;
    assign d_out       = r_d;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stage_delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_delay_sequencer
// Brief    : Directed self-checking bench for stage_delay_sequencer.
// Revision : 1.0
// ============================================================================
module tb_stage_delay_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_valid = 1'b0;
    logic [7:0] a_in = '0;
    logic       mode = 1'b0;
    logic       start_ready, busy, done;
    logic [7:0] b_out, c_out, d_out;

    logic       start_valid2 = 1'b0;
    logic [7:0] a_in2 = '0;
    logic       mode2 = 1'b0;
    logic       start_ready2, busy2, done2;
    logic [7:0] b_out2, c_out2, d_out2;

    int checks = 0;
    int failures = 0;
    int done_seen;

    always #5 clk = ~clk;

    stage_delay_sequencer #(.W(8), .DLY1(3), .DLY2(1), .CW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a_in(a_in), .mode(mode), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .busy(busy), .done(done)
    );

    stage_delay_sequencer #(.W(8), .DLY1(1), .DLY2(5), .CW(4)) u_dut_sweep (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid2), .start_ready(start_ready2),
        .a_in(a_in2), .mode(mode2), .b_out(b_out2), .c_out(c_out2), .d_out(d_out2),
        .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller sits on a negedge; accept happens at the next posedge (edge T).
    task automatic run_chain(input string tag, input logic [7:0] a0, input logic md,
                             input logic [7:0] a1, input logic [7:0] eb,
                             input logic [7:0] ec, input logic [7:0] ed);
        start_valid = 1'b1; a_in = a0; mode = md;
        @(negedge clk);
        start_valid = 1'b0;
        check({tag, "_busy_T"}, busy, 1);
        check({tag, "_ready_T"}, start_ready, 0);
        @(negedge clk);
        check({tag, "_b"}, b_out, eb);
        a_in = a1;
        repeat (3) @(negedge clk);
        check({tag, "_c"}, c_out, ec);
        check({tag, "_done_T4"}, done, 0);
        check({tag, "_busy_T4"}, busy, 1);
        @(negedge clk);
        check({tag, "_d"}, d_out, ed);
        check({tag, "_done_T5"}, done, 1);
        check({tag, "_busy_T5"}, busy, 0);
        check({tag, "_ready_T5"}, start_ready, 1);
        @(negedge clk);
        check({tag, "_done_T6"}, done, 0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_b", b_out, 0);
        check("rst_c", c_out, 0);
        check("rst_d", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_ready2", start_ready2, 1);

        run_chain("snap", 8'd4, 1'b0, 8'd4, 8'd8, 8'd12, 8'd16);
        run_chain("live", 8'd4, 1'b1, 8'd10, 8'd8, 8'd18, 8'd28);
        run_chain("snapchg", 8'd4, 1'b0, 8'd10, 8'd8, 8'd12, 8'd16);
        run_chain("wrap", 8'd200, 1'b0, 8'd200, 8'd144, 8'd88, 8'd32);

        // Back-to-back with start_valid held high throughout the first chain
        start_valid = 1'b1; a_in = 8'd4; mode = 1'b0;
        @(negedge clk);                   // after T
        a_in = 8'd5;
        @(negedge clk);                   // after T+1
        check("b2b_b1", b_out, 8);
        @(negedge clk);                   // after T+2
        check("b2b_b1_hold", b_out, 8);
        repeat (2) @(negedge clk);        // after T+4
        check("b2b_c1", c_out, 12);
        @(negedge clk);                   // after T+5
        check("b2b_d1", d_out, 16);
        check("b2b_done1", done, 1);
        check("b2b_ready", start_ready, 1);
        @(negedge clk);                   // after T+6: second accept
        start_valid = 1'b0;
        check("b2b_busy2", busy, 1);
        check("b2b_done_low", done, 0);
        check("b2b_b_held", b_out, 8);
        @(negedge clk);                   // after T+7
        check("b2b_b2", b_out, 10);
        repeat (3) @(negedge clk);        // after T+10
        check("b2b_c2", c_out, 15);
        @(negedge clk);                   // after T+11
        check("b2b_d2", d_out, 20);
        check("b2b_done2", done, 1);
        @(negedge clk);

        // Reset in the middle of WAIT_C
        start_valid = 1'b1; a_in = 8'd4; mode = 1'b0;
        @(negedge clk);                   // after T
        start_valid = 1'b0;
        @(negedge clk);                   // after T+1
        check("mid_b", b_out, 8);
        check("mid_c_held", c_out, 15);
        @(posedge clk);                   // T+2
        @(posedge clk);                   // T+3
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_b", b_out, 0);
        check("mid_rst_c", c_out, 0);
        check("mid_rst_d", d_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("mid_no_done", done_seen, 0);
        check("mid_c_unwritten", c_out, 0);
        check("mid_d_unwritten", d_out, 0);
        check("mid_ready", start_ready, 1);

        // Delay sweep instance: DLY1 = 1, DLY2 = 5
        start_valid2 = 1'b1; a_in2 = 8'd3; mode2 = 1'b0;
        @(negedge clk);                   // after T
        start_valid2 = 1'b0;
        check("sw_busy", busy2, 1);
        @(negedge clk);                   // after T+1
        check("sw_b", b_out2, 6);
        check("sw_c_early", c_out2, 0);
        @(negedge clk);                   // after T+2
        check("sw_c", c_out2, 9);
        repeat (4) @(negedge clk);        // after T+6
        check("sw_d_early", d_out2, 0);
        check("sw_done_early", done2, 0);
        @(negedge clk);                   // after T+7
        check("sw_d", d_out2, 12);
        check("sw_done", done2, 1);
        @(negedge clk);
        check("sw_done_width", done2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
